// File: rtl/chacha_stream_xor_pkg.sv
// Shared widths, FSM encoding and output beat payload for chacha_stream_xor.
package chacha_stream_xor_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned KS_W   = 512;
  localparam int unsigned LANES  = KS_W / DATA_W;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

endpackage

// File: rtl/chacha_stream_xor.sv
// XORs a byte-qualified 128-bit beat stream with 512-bit keystream blocks,
// fetching a new block every four beats or at the start of each message.
module chacha_stream_xor
  import chacha_stream_xor_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic              ks_req,
  input  logic              ks_valid,
  input  logic [KS_W-1:0]   ks_data,
  output logic [CNT_W-1:0]  blk_count,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [KS_W-1:0]    ks_buf_q, ks_buf_d;
  logic [IDX_W-1:0]   beat_idx_q, beat_idx_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic               ks_req_q, ks_req_d;
  logic               out_valid_q, out_valid_d;
  beat_t              out_q, out_d;
  logic               xfer_c;
  logic [DATA_W-1:0]  lane_c;
  logic [DATA_W-1:0]  xor_c;

  // Accept a beat only while streaming, with room in the output register, and never during clr.
  assign in_ready = (state_q == ST_STREAM) && !clr && (!out_valid_q || out_ready);
  assign xfer_c   = in_valid && in_ready;

  // Select the 128-bit keystream lane for the current beat.
  always_comb begin
    lane_c = ks_buf_q[0 +: DATA_W];
    case (beat_idx_q)
      2'd0:    lane_c = ks_buf_q[0*DATA_W +: DATA_W];
      2'd1:    lane_c = ks_buf_q[1*DATA_W +: DATA_W];
      2'd2:    lane_c = ks_buf_q[2*DATA_W +: DATA_W];
      2'd3:    lane_c = ks_buf_q[3*DATA_W +: DATA_W];
      default: lane_c = ks_buf_q[0 +: DATA_W];
    endcase
  end

  // Per-byte XOR; bytes with keep low are forced to zero.
  always_comb begin
    xor_c = '0;
    for (int i = 0; i < int'(KEEP_W); i++) begin
      xor_c[8*i +: 8] = in_keep[i] ? (in_data[8*i +: 8] ^ lane_c[8*i +: 8]) : 8'h00;
    end
  end

  // Next-state, keystream capture, lane stepping and output register loading.
  always_comb begin
    state_d     = state_q;
    ks_buf_d    = ks_buf_q;
    beat_idx_d  = beat_idx_q;
    blk_cnt_d   = blk_cnt_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (xfer_c) begin
      out_valid_d = 1'b1;
      out_d.data  = xor_c;
      out_d.keep  = in_keep;
      out_d.last  = in_last;
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (ks_valid) begin
          ks_buf_d   = ks_data;
          beat_idx_d = '0;
          blk_cnt_d  = blk_cnt_q + CNT_W'(1);
          state_d    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (xfer_c) begin
          if (in_last) begin
            state_d = ST_IDLE;
          end else if (beat_idx_q == IDX_W'(LANES - 1)) begin
            state_d = ST_REQ;
          end else begin
            beat_idx_d = beat_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Soft clear overrides every event in the cycle.
    if (clr) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      beat_idx_d  = '0;
      blk_cnt_d   = '0;
    end

    // Request line mirrors the upcoming REQ state so it is registered and exact.
    ks_req_d = (state_d == ST_REQ);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ks_buf_q    <= '0;
      beat_idx_q  <= '0;
      blk_cnt_q   <= '0;
      ks_req_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      ks_buf_q    <= ks_buf_d;
      beat_idx_q  <= beat_idx_d;
      blk_cnt_q   <= blk_cnt_d;
      ks_req_q    <= ks_req_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_keep  = out_q.keep;
  assign out_last  = out_q.last;
  assign ks_req    = ks_req_q;
  assign blk_count = blk_cnt_q;
  assign busy      = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Directed testbench for chacha_stream_xor with hand-computed expected beats.
module tb_chacha_stream_xor;

  logic         clk = 1'b0;
  logic         rst_n, clr;
  logic         in_valid, in_ready, in_last;
  logic [127:0] in_data;
  logic [15:0]  in_keep;
  logic         out_valid, out_ready, out_last;
  logic [127:0] out_data;
  logic [15:0]  out_keep;
  logic         ks_req, ks_valid;
  logic [511:0] ks_data;
  logic [31:0]  blk_count;
  logic         busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [511:0] ks_blk [4];
  logic [127:0] beat_d [8];
  logic [15:0]  beat_k [8];
  logic [127:0] exp_d  [8];
  int           xfer_cyc [8];
  int           ks_pulses, ks_cyc, first_out_cyc, stall_seen;
  logic [127:0] last_out_d;

  always #5 clk = ~clk;

  chacha_stream_xor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .ks_req    (ks_req),
    .ks_valid  (ks_valid),
    .ks_data   (ks_data),
    .blk_count (blk_count),
    .busy      (busy)
  );

  // Drive one message through, answering keystream requests and checking each output beat.
  task automatic run_msg(input int n, input int stall_after, input int stall_len, input string tag);
    int sent, recv, cyc, served, stall_left;
    logic prev_req, stalling;
    logic [127:0] held;
    sent = 0; recv = 0; cyc = 0; served = 0; stall_left = stall_len;
    prev_req = 1'b0; held = '0;
    ks_pulses = 0; ks_cyc = -1; first_out_cyc = -1; stall_seen = 0;
    while (recv < n && cyc < 200) begin
      @(negedge clk);
      if (ks_req && !prev_req) ks_pulses++;
      prev_req = ks_req;
      ks_valid = ks_req;
      if (ks_req) begin
        ks_data = ks_blk[served % 4];
        if (ks_cyc < 0) ks_cyc = cyc;
        served++;
      end
      in_valid  = (sent < n);
      in_data   = beat_d[sent % 8];
      in_keep   = beat_k[sent % 8];
      in_last   = (sent == n - 1);
      stalling  = (recv == stall_after) && (stall_left > 0) && out_valid;
      out_ready = !stalling;
      #1;
      if (stalling) begin
        stall_seen++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL %s stall_in_ready: got %b want 0", tag, in_ready);
        else pass_cnt++;
        if (stall_left < stall_len) begin
          total_cnt++;
          if (out_data !== held) $display("FAIL %s stall_hold: got %h want %h", tag, out_data, held);
          else pass_cnt++;
        end
        held = out_data;
        stall_left--;
      end
      if (in_valid && in_ready) begin
        xfer_cyc[sent % 8] = cyc;
        sent++;
      end
      if (out_valid && out_ready) begin
        if (first_out_cyc < 0) first_out_cyc = cyc;
        total_cnt++;
        if (out_data !== exp_d[recv % 8] || out_keep !== beat_k[recv % 8] || out_last !== (recv == n - 1))
          $display("FAIL %s beat%0d: got %h/%h/%b want %h/%h/%b", tag, recv, out_data, out_keep, out_last,
                   exp_d[recv % 8], beat_k[recv % 8], (recv == n - 1));
        else pass_cnt++;
        last_out_d = out_data;
        recv++;
      end
      cyc++;
    end
    total_cnt++;
    if (recv != n) $display("FAIL %s timeout: got %0d beats want %0d", tag, recv, n);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0; ks_valid = 1'b0; out_ready = 1'b1;
  endtask

  // Wait (bounded) until ks_req is seen high at a falling edge.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (ks_req) ok = 1'b1;
    end
  endtask

  task automatic load_std_blocks();
    ks_blk[0] = {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}};
    ks_blk[1] = {{16{8'hDD}}, {16{8'hCC}}, {16{8'hBB}}, {16{8'hAA}}};
    ks_blk[2] = '0;
    ks_blk[3] = '0;
    for (int j = 0; j < 8; j++) begin
      beat_d[j] = {16{8'(j)}};
      beat_k[j] = 16'hFFFF;
    end
    exp_d[0] = {16{8'h11}};
    exp_d[1] = {16{8'h23}};
    exp_d[2] = {16{8'h31}};
    exp_d[3] = {16{8'h47}};
    exp_d[4] = {16{8'hAE}};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
    out_ready = 1'b1; ks_valid = 1'b0; ks_data = '0;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, out_last, ks_req, busy} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {in_ready, out_valid, out_last, ks_req, busy});
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 128'h0 || out_keep !== 16'h0 || blk_count !== 32'h0)
      $display("FAIL reset_data: got %h/%h/%h want 0/0/0", out_data, out_keep, blk_count);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    ks_blk[0] = {384'h0, {16{8'hFF}}};
    beat_d[0] = 128'h0F0E0D0C0B0A09080706050403020100;
    beat_k[0] = 16'hFFFF;
    exp_d[0]  = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    run_msg(1, -1, 0, "single");
    total_cnt++;
    if (first_out_cyc - ks_cyc != 2) $display("FAIL single_latency: got %0d want 2", first_out_cyc - ks_cyc);
    else pass_cnt++;
    total_cnt++;
    if (blk_count !== 32'd1) $display("FAIL single_blk_count: got %0d want 1", blk_count);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || ks_req !== 1'b0) $display("FAIL single_idle: got busy=%b ks_req=%b want 0/0", busy, ks_req);
    else pass_cnt++;
  endtask

  task automatic test_multi_block();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    load_std_blocks();
    run_msg(5, -1, 0, "multi");
    total_cnt++;
    if (ks_pulses != 2) $display("FAIL multi_ks_pulses: got %0d want 2", ks_pulses);
    else pass_cnt++;
    total_cnt++;
    if (blk_count !== 32'd2) $display("FAIL multi_blk_count: got %0d want 2", blk_count);
    else pass_cnt++;
    total_cnt++;
    if (xfer_cyc[3] - xfer_cyc[0] != 3) $display("FAIL multi_no_bubble: got %0d want 3", xfer_cyc[3] - xfer_cyc[0]);
    else pass_cnt++;
  endtask

  task automatic test_partial();
    load_std_blocks();
    beat_d[0] = {16{8'hF0}};
    exp_d[0]  = {16{8'hE1}};
    beat_d[1] = 128'h0123456789ABCDEFFEDCBA9876543210;
    beat_k[1] = 16'h000F;
    exp_d[1]  = 128'h00000000000000000000000054761032;
    run_msg(2, -1, 0, "partial");
    total_cnt++;
    if (last_out_d[127:32] !== 96'h0) $display("FAIL partial_upper_zero: got %h want 0", last_out_d[127:32]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back_backpressure();
    load_std_blocks();
    run_msg(4, 1, 5, "backpressure");
    total_cnt++;
    if (stall_seen != 5) $display("FAIL backpressure_stall_cycles: got %0d want 5", stall_seen);
    else pass_cnt++;
  endtask

  task automatic test_clr();
    bit ok;
    load_std_blocks();
    in_valid = 1'b1; in_data = beat_d[0]; in_keep = 16'hFFFF; in_last = 1'b1; out_ready = 1'b1;
    wait_req(ok);
    total_cnt++;
    if (!ok) $display("FAIL clr_req_seen: got 0 want 1");
    else pass_cnt++;
    in_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    ks_valid = 1'b1; ks_data = ks_blk[0];
    @(negedge clk);
    ks_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (ks_req !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || blk_count !== 32'd0)
      $display("FAIL clr_in_req: got ks_req=%b busy=%b out_valid=%b blk=%0d want 0/0/0/0",
               ks_req, busy, out_valid, blk_count);
    else pass_cnt++;
    // clear while a beat is offered in STREAM
    in_valid = 1'b1;
    wait_req(ok);
    ks_valid = 1'b1; ks_data = ks_blk[0];
    @(negedge clk);
    ks_valid = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL clr_stream_ready: got %b want 1", in_ready);
    else pass_cnt++;
    clr = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL clr_forces_ready: got %b want 0", in_ready);
    else pass_cnt++;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || blk_count !== 32'd0)
      $display("FAIL clr_stream_abort: got out_valid=%b busy=%b blk=%0d want 0/0/0", out_valid, busy, blk_count);
    else pass_cnt++;
  endtask

  task automatic test_stray_and_async_reset();
    bit ok;
    load_std_blocks();
    @(negedge clk);
    ks_valid = 1'b1; ks_data = ks_blk[1];
    @(negedge clk);
    ks_valid = 1'b0;
    total_cnt++;
    if (blk_count !== 32'd0 || busy !== 1'b0 || out_valid !== 1'b0 || ks_req !== 1'b0)
      $display("FAIL stray_ks: got blk=%0d busy=%b out_valid=%b ks_req=%b want 0/0/0/0",
               blk_count, busy, out_valid, ks_req);
    else pass_cnt++;
    in_valid = 1'b1; in_data = beat_d[1]; in_keep = 16'hFFFF; in_last = 1'b0; out_ready = 1'b0;
    wait_req(ok);
    ks_valid = 1'b1; ks_data = ks_blk[0];
    @(negedge clk);
    ks_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== {16{8'h10}})
      $display("FAIL arst_pre_out: got %b/%h want 1/%h", out_valid, out_data, {16{8'h10}});
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, out_last, ks_req, busy} !== 5'b0 || out_data !== 128'h0 ||
        out_keep !== 16'h0 || blk_count !== 32'h0)
      $display("FAIL arst_immediate: got ctl=%b data=%h keep=%h blk=%0d want 0", 
               {in_ready, out_valid, out_last, ks_req, busy}, out_data, out_keep, blk_count);
    else pass_cnt++;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || ks_req !== 1'b0)
      $display("FAIL arst_after: got out_valid=%b busy=%b ks_req=%b want 0/0/0", out_valid, busy, ks_req);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_block();
    test_partial();
    test_back_to_back_backpressure();
    test_clr();
    test_stray_and_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
